// File: rtl/hold_grab_arbiter_pkg.sv
// Shared types and constants for the hold grab arbiter: table geometry,
// coordinate widths, reset hold positions and the sequencer state encoding.
package hold_pkg;

  localparam int N_HOLDS       = 15;
  localparam int IDX_WIDTH     = 4;
  localparam int RADIUS_SQ_DEF = 150;

  localparam int X_W  = 12;  // hold / screen-origin x
  localparam int Y_W  = 13;  // hold / screen-origin y
  localparam int HX_W = 11;  // hand screen x
  localparam int HY_W = 10;  // hand screen y
  localparam int WX_W = 13;  // hand world x
  localparam int WY_W = 14;  // hand world y
  localparam int D_W  = 29;  // squared distance

  typedef struct packed {
    logic signed [X_W-1:0] x;
    logic signed [Y_W-1:0] y;
  } hold_pos_t;

  typedef hold_pos_t hold_tab_t [N_HOLDS];

  localparam hold_tab_t HOLD_DEFAULTS = '{
    '{x:  12'sd400, y:   13'sd50},
    '{x:  12'sd300, y:  13'sd100},
    '{x:  12'sd200, y:  13'sd300},
    '{x:  12'sd600, y:  13'sd200},
    '{x:  12'sd100, y: -13'sd100},
    '{x:  12'sd450, y: -13'sd550},
    '{x:  12'sd700, y:  13'sd400},
    '{x: -12'sd200, y:  13'sd150},
    '{x:  12'sd800, y: -13'sd300},
    '{x:   12'sd50, y:  13'sd600},
    '{x: 12'sd1000, y:    13'sd0},
    '{x: -12'sd500, y: -13'sd500},
    '{x: 12'sd1500, y:  13'sd900},
    '{x:  12'sd250, y: -13'sd1000},
    '{x:  12'sd900, y:  13'sd700}
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ARB   = 3'd3,
    ST_WR0   = 3'd4,
    ST_WR1   = 3'd5
  } hga_state_e;

  // Entries beyond the default table (larger NUM_HOLDS builds) reset to the origin.
  function automatic hold_pos_t hold_default(input int idx);
    if (idx >= 0 && idx < N_HOLDS) return HOLD_DEFAULTS[idx];
    return '0;
  endfunction

endpackage

// File: rtl/hold_grab_arbiter_if.sv
// Frame-control, hand-tracking and renderer read-port bundle of the hold grab arbiter.
interface hold_grab_arbiter_if
  import hold_pkg::*;
#(
  parameter int IDX_W = IDX_WIDTH
);
  // No valid/ready pairs here: frame_tick is a one-cycle start strobe sampled only
  // while the sequencer is idle (hand/screen inputs are captured on that cycle),
  // and the read port is free-running: rd_idx in cycle N gives rd_x/rd_y in cycle N+1.
  logic                   frame_tick;
  logic                   edit_en;
  logic signed [X_W-1:0]  screenx;
  logic signed [Y_W-1:0]  screeny;
  logic [HX_W-1:0]        hand0_x;
  logic [HX_W-1:0]        hand1_x;
  logic [HY_W-1:0]        hand0_y;
  logic [HY_W-1:0]        hand1_y;
  logic                   grab0;
  logic                   grab1;
  logic [IDX_W-1:0]       rd_idx;
  logic signed [X_W-1:0]  rd_x;
  logic signed [Y_W-1:0]  rd_y;
  logic [1:0]             own_valid;
  logic [IDX_W-1:0]       own_idx0;
  logic [IDX_W-1:0]       own_idx1;
  logic                   busy;
  logic                   overrun;

  modport master (
    output frame_tick, edit_en, screenx, screeny,
    output hand0_x, hand1_x, hand0_y, hand1_y, grab0, grab1, rd_idx,
    input  rd_x, rd_y, own_valid, own_idx0, own_idx1, busy, overrun
  );

  modport slave (
    input  frame_tick, edit_en, screenx, screeny,
    input  hand0_x, hand1_x, hand0_y, hand1_y, grab0, grab1, rd_idx,
    output rd_x, rd_y, own_valid, own_idx0, own_idx1, busy, overrun
  );
endinterface

// File: rtl/hold_grab_arbiter_dist_sq.sv
// Two-stage squared distance between a hand world position and one hold:
// stage 1 squares the axis deltas, stage 2 sums them. Index and valid ride along.
module hold_dist_sq
  import hold_pkg::*;
#(
  parameter int IDX_W = IDX_WIDTH
) (
  input  logic                   vclock,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic signed [WX_W-1:0] i_wx,
  input  logic signed [WY_W-1:0] i_wy,
  input  hold_pos_t              i_pos,
  output logic                   o_valid,
  output logic [IDX_W-1:0]       o_idx,
  output logic [D_W-1:0]         o_d
);
  logic signed [WX_W-1:0] w_dx;
  logic signed [WY_W-1:0] w_dy;
  logic signed [D_W-1:0]  w_dx_e;
  logic signed [D_W-1:0]  w_dy_e;

  logic                   r_v1;
  logic [IDX_W-1:0]       r_idx1;
  logic [D_W-1:0]         r_sq_x;
  logic [D_W-1:0]         r_sq_y;
  logic                   r_v2;
  logic [IDX_W-1:0]       r_idx2;
  logic [D_W-1:0]         r_d;

  // Deltas wrap at the world-coordinate widths; squares are taken on sign-extended copies.
  assign w_dx   = i_wx - {i_pos.x[X_W-1], i_pos.x};
  assign w_dy   = i_wy - {i_pos.y[Y_W-1], i_pos.y};
  assign w_dx_e = D_W'(w_dx);
  assign w_dy_e = D_W'(w_dy);

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_idx1 <= '0;
      r_sq_x <= '0;
      r_sq_y <= '0;
      r_v2   <= 1'b0;
      r_idx2 <= '0;
      r_d    <= '0;
    end else begin
      r_v1   <= i_valid;
      r_idx1 <= i_idx;
      r_sq_x <= w_dx_e * w_dx_e;
      r_sq_y <= w_dy_e * w_dy_e;
      r_v2   <= r_v1;
      r_idx2 <= r_idx1;
      r_d    <= r_sq_x + r_sq_y;
    end
  end

  assign o_valid = r_v2;
  assign o_idx   = r_idx2;
  assign o_d     = r_d;
endmodule

// File: rtl/hold_grab_arbiter.sv
// Frame-sequenced hold table owner: scans holds for the nearest grab hit per hand,
// arbitrates ownership and drags owned holds. Optional HOLD_GRAB_SNAP_EN snaps writes to 8 units.
module hold_grab_arbiter
  import hold_pkg::*;
#(
  parameter int          NUM_HOLDS = N_HOLDS,
  parameter int          IDX_W     = IDX_WIDTH,
  parameter int unsigned RADIUS_SQ = RADIUS_SQ_DEF
) (
  input  logic                vclock,
  input  logic                reset,
  hold_grab_arbiter_if.slave  bus,
  output hga_state_e          o_state
);
  hga_state_e             r_state;
  hga_state_e             w_next_state;
  logic [IDX_W-1:0]       r_scan_idx;
  logic                   r_drain_cnt;

  logic                   r_edit;
  logic [1:0]             r_grab;
  logic [1:0]             r_prev_grab;
  logic                   r_prio;
  logic signed [WX_W-1:0] r_wx [2];
  logic signed [WY_W-1:0] r_wy [2];
  logic signed [WX_W-1:0] w_wx [2];
  logic signed [WY_W-1:0] w_wy [2];

  logic [1:0]             r_best_hit;
  logic [D_W-1:0]         r_best_d   [2];
  logic [IDX_W-1:0]       r_best_idx [2];
  logic [1:0]             w_dv;
  logic [IDX_W-1:0]       w_didx [2];
  logic [D_W-1:0]         w_d    [2];

  logic [1:0]             r_own_valid;
  logic [IDX_W-1:0]       r_own_idx [2];
  logic [1:0]             w_keep;
  logic [1:0]             w_acq;
  logic [1:0]             w_new_valid;
  logic [IDX_W-1:0]       w_new_idx [2];
  logic                   w_prio_next;

  hold_pos_t              r_table [NUM_HOLDS];
  hold_pos_t              w_scan_pos;
  hold_pos_t              w_wr_pos;
  logic                   w_wr_h;
  hold_pos_t              r_rd;
  logic                   r_overrun;
  logic                   w_start;

  assign w_start = (r_state == ST_IDLE) && bus.frame_tick;

  assign w_wx[0] = {bus.screenx[X_W-1], bus.screenx} + {{(WX_W-HX_W){1'b0}}, bus.hand0_x};
  assign w_wx[1] = {bus.screenx[X_W-1], bus.screenx} + {{(WX_W-HX_W){1'b0}}, bus.hand1_x};
  assign w_wy[0] = {bus.screeny[Y_W-1], bus.screeny} + {{(WY_W-HY_W){1'b0}}, bus.hand0_y};
  assign w_wy[1] = {bus.screeny[Y_W-1], bus.screeny} + {{(WY_W-HY_W){1'b0}}, bus.hand1_y};

  always_ff @(posedge vclock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.frame_tick) w_next_state = ST_SCAN;
      ST_SCAN:  if (r_scan_idx == IDX_W'(NUM_HOLDS - 1)) w_next_state = ST_DRAIN;
      ST_DRAIN: if (r_drain_cnt) w_next_state = ST_ARB;
      ST_ARB:   w_next_state = ST_WR0;
      ST_WR0:   w_next_state = ST_WR1;
      ST_WR1:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_scan_idx  <= '0;
      r_drain_cnt <= 1'b0;
    end else begin
      if (w_start) r_scan_idx <= '0;
      else if (r_state == ST_SCAN) r_scan_idx <= r_scan_idx + 1'b1;
      r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
    end
  end

  // Everything after the tick works on this snapshot, never on live hand inputs.
  always_ff @(posedge vclock) begin
    if (reset) begin
      r_edit <= 1'b0;
      r_grab <= 2'b00;
      for (int h = 0; h < 2; h++) begin
        r_wx[h] <= '0;
        r_wy[h] <= '0;
      end
    end else if (w_start) begin
      r_edit <= bus.edit_en;
      r_grab <= {bus.grab1, bus.grab0};
      for (int h = 0; h < 2; h++) begin
        r_wx[h] <= w_wx[h];
        r_wy[h] <= w_wy[h];
      end
    end
  end

  assign w_scan_pos = r_table[r_scan_idx];

  for (genvar g = 0; g < 2; g++) begin : g_dist
    hold_dist_sq #(.IDX_W(IDX_W)) u_dist (
      .vclock  (vclock),
      .reset   (reset),
      .i_valid (r_state == ST_SCAN),
      .i_idx   (r_scan_idx),
      .i_wx    (r_wx[g]),
      .i_wy    (r_wy[g]),
      .i_pos   (w_scan_pos),
      .o_valid (w_dv[g]),
      .o_idx   (w_didx[g]),
      .o_d     (w_d[g])
    );
  end

  // Strict less-than on both tests keeps the lowest index among equal distances.
  always_ff @(posedge vclock) begin
    if (reset || w_start) begin
      r_best_hit <= 2'b00;
      for (int h = 0; h < 2; h++) begin
        r_best_d[h]   <= '0;
        r_best_idx[h] <= '0;
      end
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (w_dv[h] && (w_d[h] < D_W'(RADIUS_SQ)) &&
            (!r_best_hit[h] || (w_d[h] < r_best_d[h]))) begin
          r_best_hit[h] <= 1'b1;
          r_best_d[h]   <= w_d[h];
          r_best_idx[h] <= w_didx[h];
        end
      end
    end
  end

  always_comb begin
    w_keep      = 2'b00;
    w_acq       = 2'b00;
    w_new_valid = 2'b00;
    w_prio_next = r_prio;
    for (int h = 0; h < 2; h++) begin
      w_new_idx[h] = r_own_idx[h];
      w_keep[h]    = r_edit && r_grab[h] && r_own_valid[h];
    end
    for (int h = 0; h < 2; h++) begin
      w_acq[h] = r_edit && r_grab[h] && !r_own_valid[h] && !r_prev_grab[h] &&
                 r_best_hit[h] && !(w_keep[1-h] && (r_own_idx[1-h] == r_best_idx[h]));
    end
    if ((w_acq == 2'b11) && (r_best_idx[0] == r_best_idx[1])) begin
      if (r_prio) w_acq[0] = 1'b0;
      else        w_acq[1] = 1'b0;
      w_prio_next = ~r_prio;
    end
    for (int h = 0; h < 2; h++) begin
      w_new_valid[h] = w_keep[h] | w_acq[h];
      if (w_acq[h]) w_new_idx[h] = r_best_idx[h];
    end
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_own_valid <= 2'b00;
      r_prev_grab <= 2'b00;
      r_prio      <= 1'b0;
      for (int h = 0; h < 2; h++) r_own_idx[h] <= '0;
    end else if (r_state == ST_ARB) begin
      r_own_valid <= w_new_valid;
      r_prev_grab <= r_grab;
      r_prio      <= w_prio_next;
      for (int h = 0; h < 2; h++) r_own_idx[h] <= w_new_idx[h];
    end
  end

  always_comb begin
    w_wr_h     = (r_state == ST_WR1);
    w_wr_pos.x = r_wx[w_wr_h][X_W-1:0];
    w_wr_pos.y = r_wy[w_wr_h][Y_W-1:0];
`ifdef HOLD_GRAB_SNAP_EN
    w_wr_pos.x[2:0] = 3'b000;
    w_wr_pos.y[2:0] = 3'b000;
`endif
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOLDS; i++) r_table[i] <= hold_default(i);
    end else begin
      if ((r_state == ST_WR0) && r_own_valid[0]) r_table[r_own_idx[0]] <= w_wr_pos;
      if ((r_state == ST_WR1) && r_own_valid[1]) r_table[r_own_idx[1]] <= w_wr_pos;
    end
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_rd      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_rd      <= (32'(bus.rd_idx) < NUM_HOLDS) ? r_table[bus.rd_idx] : '0;
      r_overrun <= bus.frame_tick && (r_state != ST_IDLE);
    end
  end

  assign bus.rd_x      = r_rd.x;
  assign bus.rd_y      = r_rd.y;
  assign bus.own_valid = r_own_valid;
  assign bus.own_idx0  = r_own_idx[0];
  assign bus.own_idx1  = r_own_idx[1];
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.overrun   = r_overrun;
  assign o_state       = r_state;
endmodule

// File: tb/tb_hold_grab_arbiter.sv
// Self-checking bench for hold_grab_arbiter: reset, grab/drag, contention, release,
// edit-off with overrun, grab-radius boundary and screen offset.
module tb_hold_grab_arbiter;
  import hold_pkg::*;

  logic       vclock = 1'b0;
  logic       reset  = 1'b1;
  hga_state_e dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [24:0] exp_q[$];

  hold_grab_arbiter_if #(.IDX_W(4)) bus ();

  hold_grab_arbiter #(.NUM_HOLDS(15), .IDX_W(4), .RADIUS_SQ(150)) dut (
    .vclock  (vclock),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #5 vclock = ~vclock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] pos(input int x, input int y);
    logic [11:0] px;
    logic [12:0] py;
    px = x[11:0];
    py = y[12:0];
    return {px, py};
  endfunction

  function automatic logic [24:0] wr_pos(input int x, input int y);
`ifdef HOLD_GRAB_SNAP_EN
    return pos(x & ~7, y & ~7);
`else
    return pos(x, y);
`endif
  endfunction

  task automatic step();
    @(posedge vclock);
    #1;
  endtask

  task automatic set_hand(input int h, input int x, input int y, input logic g);
    if (h == 0) begin
      bus.hand0_x = 11'(x); bus.hand0_y = 10'(y); bus.grab0 = g;
    end else begin
      bus.hand1_x = 11'(x); bus.hand1_y = 10'(y); bus.grab1 = g;
    end
  endtask

  task automatic read_hold(input int idx, output logic [24:0] got);
    bus.rd_idx = idx[3:0];
    step();
    got = {bus.rd_x, bus.rd_y};
  endtask

  task automatic run_frame(output int busy_n);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    busy_n = 0;
    while (bus.busy && busy_n < 100) begin
      busy_n++;
      step();
    end
    if (busy_n >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: busy still high after %0d cycles", busy_n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
  endtask

  // Pops expected positions pushed by the caller and compares them against reads.
  task automatic drain_reads(input string name, input int idx0, input int idx1, input int idx2, input int n);
    int idxs[3];
    logic [24:0] got, exp;
    idxs = '{idx0, idx1, idx2};
    for (int i = 0; i < n; i++) begin
      read_hold(idxs[i], got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s: idx %0d got (%0d,%0d) expected (%0d,%0d)", name, idxs[i],
                 $signed(got[24:13]), $signed(got[12:0]), $signed(exp[24:13]), $signed(exp[12:0]));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (bus.own_valid !== 2'b00) begin n_fail++; $display("FAIL reset_own_valid: got %b expected 00", bus.own_valid); end
    n_checks++; if (bus.own_idx0 !== 4'd0) begin n_fail++; $display("FAIL reset_own_idx0: got %0d expected 0", bus.own_idx0); end
    n_checks++; if (bus.own_idx1 !== 4'd0) begin n_fail++; $display("FAIL reset_own_idx1: got %0d expected 0", bus.own_idx1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    n_checks++; if ({bus.rd_x, bus.rd_y} !== 25'd0) begin n_fail++; $display("FAIL reset_rd: got (%0d,%0d) expected (0,0)", bus.rd_x, bus.rd_y); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    step();
    exp_q.push_back(pos(400, 50));
    exp_q.push_back(pos(300, 100));
    exp_q.push_back(pos(450, -550));
    drain_reads("reset_table", 0, 1, 5, 3);
  endtask

  task automatic test_grab_drag();
    int busy_n;
    bus.edit_en = 1'b1; bus.screenx = '0; bus.screeny = '0;
    set_hand(0, 405, 55, 1'b1);
    run_frame(busy_n);
    n_checks++; if (busy_n != 20) begin n_fail++; $display("FAIL grab_busy_len: got %0d expected 20", busy_n); end
    n_checks++; if (bus.own_valid !== 2'b01) begin n_fail++; $display("FAIL grab_own_valid: got %b expected 01", bus.own_valid); end
    n_checks++; if (bus.own_idx0 !== 4'd0) begin n_fail++; $display("FAIL grab_own_idx0: got %0d expected 0", bus.own_idx0); end
    exp_q.push_back(wr_pos(405, 55));
    drain_reads("grab_first_write", 0, 0, 0, 1);
    set_hand(0, 420, 60, 1'b1);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b01) begin n_fail++; $display("FAIL drag_own_valid: got %b expected 01", bus.own_valid); end
    exp_q.push_back(wr_pos(420, 60));
    exp_q.push_back(pos(300, 100));
    drain_reads("drag_write", 0, 1, 0, 2);
  endtask

  task automatic test_release();
    int busy_n;
    set_hand(0, 420, 60, 1'b0);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b00) begin n_fail++; $display("FAIL release_own_valid: got %b expected 00", bus.own_valid); end
    set_hand(0, 300, 300, 1'b0);
    run_frame(busy_n);
    exp_q.push_back(wr_pos(420, 60));
    drain_reads("release_no_move", 0, 0, 0, 1);
  endtask

  task automatic test_contention();
    int busy_n;
    do_reset();
    exp_q.push_back(pos(400, 50));
    drain_reads("reset_reload", 0, 0, 0, 1);
    bus.edit_en = 1'b1;
    set_hand(0, 402, 52, 1'b1);
    set_hand(1, 402, 52, 1'b1);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b01) begin n_fail++; $display("FAIL contend1_own_valid: got %b expected 01", bus.own_valid); end
    n_checks++; if (bus.own_idx0 !== 4'd0) begin n_fail++; $display("FAIL contend1_own_idx0: got %0d expected 0", bus.own_idx0); end
    exp_q.push_back(wr_pos(402, 52));
    drain_reads("contend1_write", 0, 0, 0, 1);
    set_hand(0, 402, 52, 1'b0);
    set_hand(1, 402, 52, 1'b0);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b00) begin n_fail++; $display("FAIL contend_release: got %b expected 00", bus.own_valid); end
    set_hand(0, 402, 52, 1'b1);
    set_hand(1, 402, 52, 1'b1);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b10) begin n_fail++; $display("FAIL contend2_own_valid: got %b expected 10", bus.own_valid); end
    n_checks++; if (bus.own_idx1 !== 4'd0) begin n_fail++; $display("FAIL contend2_own_idx1: got %0d expected 0", bus.own_idx1); end
    set_hand(0, 2000, 1000, 1'b0);
    set_hand(1, 2000, 1000, 1'b0);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b00) begin n_fail++; $display("FAIL contend2_release: got %b expected 00", bus.own_valid); end
  endtask

  task automatic test_edit_off_overrun();
    int busy_n, ov_cnt, ov_cycle;
    bus.edit_en = 1'b0;
    set_hand(0, 301, 101, 1'b1);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    busy_n = 0; ov_cnt = 0; ov_cycle = -1;
    for (int c = 1; c < 40; c++) begin
      if (bus.busy) busy_n++;
      if (bus.overrun) begin ov_cnt++; ov_cycle = c; end
      bus.frame_tick = (c == 5);
      step();
    end
    bus.frame_tick = 1'b0;
    n_checks++; if (busy_n != 20) begin n_fail++; $display("FAIL overrun_busy_len: got %0d expected 20", busy_n); end
    n_checks++; if (ov_cnt != 1) begin n_fail++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt); end
    n_checks++; if (ov_cycle != 6) begin n_fail++; $display("FAIL overrun_cycle: got %0d expected 6", ov_cycle); end
    n_checks++; if (bus.own_valid !== 2'b00) begin n_fail++; $display("FAIL edit_off_own_valid: got %b expected 00", bus.own_valid); end
    exp_q.push_back(pos(300, 100));
    drain_reads("edit_off_table", 1, 0, 0, 1);
    set_hand(0, 2000, 1000, 1'b0);
    run_frame(busy_n);
  endtask

  task automatic test_radius_and_offset();
    int busy_n;
    do_reset();
    bus.edit_en = 1'b1; bus.screenx = '0; bus.screeny = '0;
    // 150 is not a sum of two squares; 153 (12,3) is the closest reachable miss.
    set_hand(0, 412, 53, 1'b1);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b00) begin n_fail++; $display("FAIL radius_d153: got %b expected 00", bus.own_valid); end
    set_hand(0, 412, 53, 1'b0);
    run_frame(busy_n);
    set_hand(0, 410, 57, 1'b1);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b01) begin n_fail++; $display("FAIL radius_d149: got %b expected 01", bus.own_valid); end
    n_checks++; if (bus.own_idx0 !== 4'd0) begin n_fail++; $display("FAIL radius_d149_idx: got %0d expected 0", bus.own_idx0); end
    exp_q.push_back(wr_pos(410, 57));
    drain_reads("radius_write", 0, 0, 0, 1);
    set_hand(0, 410, 57, 1'b0);
    run_frame(busy_n);
    bus.screenx = -12'sd100; bus.screeny = -13'sd600;
    set_hand(0, 550, 52, 1'b1);
    run_frame(busy_n);
    n_checks++; if (bus.own_valid !== 2'b01) begin n_fail++; $display("FAIL offset_own_valid: got %b expected 01", bus.own_valid); end
    n_checks++; if (bus.own_idx0 !== 4'd5) begin n_fail++; $display("FAIL offset_own_idx0: got %0d expected 5", bus.own_idx0); end
    exp_q.push_back(wr_pos(450, -548));
    exp_q.push_back(wr_pos(410, 57));
    drain_reads("offset_write", 5, 0, 0, 2);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.edit_en    = 1'b0;
    bus.screenx    = '0;
    bus.screeny    = '0;
    bus.rd_idx     = '0;
    set_hand(0, 2000, 1000, 1'b0);
    set_hand(1, 2000, 1000, 1'b0);
    test_reset();
    test_grab_drag();
    test_release();
    test_contention();
    test_edit_off_overrun();
    test_radius_and_offset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
